// File: rtl/operand_ctrl_pkg.sv
// Shared types for the operand load arbiter.
//   arb_state_t : drain FSM states (RUN, DRAIN, HALTED)
//   target_e    : load target selector (TGT_A = regA, TGT_B = regB)
//   REQ_ID_W    : width of a requester id for n requesters
package operand_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } arb_state_t;

  typedef enum logic {
    TGT_A = 1'b0,
    TGT_B = 1'b1
  } target_e;

  function automatic int REQ_ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, purely combinational.
//   req    : request vector (N bits)
//   ptr    : highest-priority index this cycle
//   gnt    : one-hot grant (all zero when nothing requests)
//   gnt_id : binary index of the granted requester
//   any    : at least one request present
module rr_arbiter
  import operand_ctrl_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = REQ_ID_W(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  logic [N-1:0] masked;
  logic         found;

  // Two-pass search: first the requests at or above ptr, then wrap to the
  // lowest request overall.
  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = req[i] && (i >= int'(ptr));
    end

    found  = 1'b0;
    gnt_id = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && masked[i]) begin
        found  = 1'b1;
        gnt_id = ID_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        gnt_id = ID_W'(i);
      end
    end

    any = |req;
    gnt = any ? ({{(N-1){1'b0}}, 1'b1} << gnt_id) : '0;
  end

endmodule

// File: rtl/operand_load_arbiter.sv
// Operand load arbiter: shares the load ports of regA and regB among
// NUM_REQ requesters with one round-robin arbiter per target, tracks every
// issued load through the register pipeline and pulses a per-target done
// with the requester id once the register output shows the data. A drain
// FSM blocks new grants and reports when both pipelines are empty.
//   clk, reset_n              : clock, async active-low reset
//   req_valid/sel_b/data      : per-requester request, target, operand
//   req_ready                 : per-requester grant (combinational)
//   drain_req / drained       : drain request level / halted indication
//   load_a/b, data_in_a/b     : registered load ports to regA / regB
//   done_a/b_valid, _id       : completion pulse and requester id
module operand_load_arbiter
  import operand_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_sel_b,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          drain_req,
  output logic                          drained,
  output logic                          load_a,
  output logic [DATA_WIDTH-1:0]         data_in_a,
  output logic                          load_b,
  output logic [DATA_WIDTH-1:0]         data_in_b,
  output logic                          done_a_valid,
  output logic [$clog2(NUM_REQ)-1:0]    done_a_id,
  output logic                          done_b_valid,
  output logic [$clog2(NUM_REQ)-1:0]    done_b_id
);

  localparam int ID_W = REQ_ID_W(NUM_REQ);

  arb_state_t state;

  logic [ID_W-1:0]       ptr_a, ptr_b;
  logic [NUM_REQ-1:0]    cand_a, cand_b;
  logic [NUM_REQ-1:0]    gnt_a, gnt_b;
  logic [ID_W-1:0]       gnt_id_a, gnt_id_b;
  logic                  any_a, any_b;
  logic                  grant_en;
  logic                  hs_a, hs_b;
  logic [DATA_WIDTH-1:0] gnt_data_a, gnt_data_b;
  logic                  in_flight;

  // Per-target valid/id shift pipes. Stage 0 coincides with the load port,
  // stage LATENCY is the cycle the register output shows the data.
  logic [LATENCY:0]      vld_a, vld_b;
  logic [ID_W-1:0]       id_a [LATENCY:0];
  logic [ID_W-1:0]       id_b [LATENCY:0];

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    if (int'(id) == NUM_REQ - 1) return '0;
    else                         return id + 1'b1;
  endfunction

  assign cand_a = req_valid & ~req_sel_b;
  assign cand_b = req_valid &  req_sel_b;

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb_a (
    .req    (cand_a),
    .ptr    (ptr_a),
    .gnt    (gnt_a),
    .gnt_id (gnt_id_a),
    .any    (any_a)
  );

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb_b (
    .req    (cand_b),
    .ptr    (ptr_b),
    .gnt    (gnt_b),
    .gnt_id (gnt_id_b),
    .any    (any_b)
  );

  // drain_req kills grants in the same cycle it rises; reset_n gating keeps
  // req_ready low while reset is held.
  assign grant_en  = reset_n && (state == RUN) && !drain_req;
  assign req_ready = (gnt_a | gnt_b) & {NUM_REQ{grant_en}};
  assign hs_a      = grant_en && any_a;
  assign hs_b      = grant_en && any_b;

  assign gnt_data_a = req_data[int'(gnt_id_a)*DATA_WIDTH +: DATA_WIDTH];
  assign gnt_data_b = req_data[int'(gnt_id_b)*DATA_WIDTH +: DATA_WIDTH];

  // Anything in stages below the done stage will still produce a done after
  // this edge; the done stage itself is allowed so drained follows the last
  // done by exactly one cycle.
  assign in_flight = (|vld_a[LATENCY-1:0]) || (|vld_b[LATENCY-1:0]);

  // ---- issue stage: pointers and load data registers ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_a     <= '0;
      ptr_b     <= '0;
      data_in_a <= '0;
      data_in_b <= '0;
    end else begin
      if (hs_a) begin
        ptr_a     <= next_ptr(gnt_id_a);
        data_in_a <= gnt_data_a;
      end
      if (hs_b) begin
        ptr_b     <= next_ptr(gnt_id_b);
        data_in_b <= gnt_data_b;
      end
    end
  end

  // ---- completion pipes ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_a <= '0;
      vld_b <= '0;
      for (int k = 0; k <= LATENCY; k++) begin
        id_a[k] <= '0;
        id_b[k] <= '0;
      end
    end else begin
      vld_a   <= {vld_a[LATENCY-1:0], hs_a};
      vld_b   <= {vld_b[LATENCY-1:0], hs_b};
      id_a[0] <= gnt_id_a;
      id_b[0] <= gnt_id_b;
      for (int k = 1; k <= LATENCY; k++) begin
        id_a[k] <= id_a[k-1];
        id_b[k] <= id_b[k-1];
      end
    end
  end

  assign load_a       = vld_a[0];
  assign load_b       = vld_b[0];
  assign done_a_valid = vld_a[LATENCY];
  assign done_b_valid = vld_b[LATENCY];
  assign done_a_id    = id_a[LATENCY];
  assign done_b_id    = id_b[LATENCY];

  // ---- drain FSM ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (drain_req) state <= DRAIN;
        DRAIN: begin
          if (!drain_req)      state <= RUN;
          else if (!in_flight) state <= HALTED;
        end
        HALTED:  if (!drain_req) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign drained = (state == HALTED);

endmodule

// File: tb/tb_operand_load_arbiter.sv
module tb_operand_load_arbiter;

  localparam int DW  = 32;
  localparam int N   = 4;
  localparam int L   = 2;
  localparam int IDW = 2;
  localparam int SL  = 32;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_sel_b;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            drain_req;
  logic            drained;
  logic            load_a, load_b;
  logic [DW-1:0]   data_in_a, data_in_b;
  logic            done_a_valid, done_b_valid;
  logic [IDW-1:0]  done_a_id, done_b_id;

  operand_load_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .LATENCY(L)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_sel_b    (req_sel_b),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .drain_req    (drain_req),
    .drained      (drained),
    .load_a       (load_a),
    .data_in_a    (data_in_a),
    .load_b       (load_b),
    .data_in_b    (data_in_b),
    .done_a_valid (done_a_valid),
    .done_a_id    (done_a_id),
    .done_b_valid (done_b_valid),
    .done_b_id    (done_b_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: spec-level timeline. A grant in cycle c books a load
  // event at c+1 and a done event at c+1+L into circular slot tables.
  int          cyc;
  int          ptr_m [2];
  int          mst;            // 0 = RUN, 1 = DRAIN, 2 = HALTED
  bit          sl_load [2][SL];
  logic [DW-1:0] sl_data [2][SL];
  bit          sl_done [2][SL];
  int          sl_id   [2][SL];
  logic [DW-1:0] last_d [2];
  bit [N-1:0]  acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < 2; t++) begin
      ptr_m[t]  = 0;
      last_d[t] = '0;
      for (int s = 0; s < SL; s++) begin
        sl_load[t][s] = 1'b0;
        sl_data[t][s] = '0;
        sl_done[t][s] = 1'b0;
        sl_id[t][s]   = 0;
      end
    end
    mst = 0;
  endtask

  // One clock cycle: check all outputs against the model, advance the
  // model, then step to the next falling edge where stimulus may change.
  task automatic cycle(output bit [N-1:0] granted);
    int g [2];
    bit en;
    bit pending;
    int s;
    #1;
    if (!reset_n) model_reset();
    en = reset_n && (mst == 0) && !drain_req;
    granted = '0;
    for (int t = 0; t < 2; t++) begin
      g[t] = -1;
      if (en) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (ptr_m[t] + k) % N;
          if (g[t] < 0 && req_valid[idx] && (req_sel_b[idx] == 1'(t))) g[t] = idx;
        end
      end
      if (g[t] >= 0) granted[g[t]] = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(granted));

    s = cyc % SL;
    for (int t = 0; t < 2; t++) if (sl_load[t][s]) last_d[t] = sl_data[t][s];
    chk("load_a", 64'(load_a), 64'(sl_load[0][s]));
    chk("load_b", 64'(load_b), 64'(sl_load[1][s]));
    chk("data_in_a", 64'(data_in_a), 64'(last_d[0]));
    chk("data_in_b", 64'(data_in_b), 64'(last_d[1]));
    chk("done_a_valid", 64'(done_a_valid), 64'(sl_done[0][s]));
    chk("done_b_valid", 64'(done_b_valid), 64'(sl_done[1][s]));
    if (sl_done[0][s]) chk("done_a_id", 64'(done_a_id), 64'(sl_id[0][s]));
    if (sl_done[1][s]) chk("done_b_id", 64'(done_b_id), 64'(sl_id[1][s]));
    chk("drained", 64'(drained), 64'(mst == 2));
    for (int t = 0; t < 2; t++) begin
      sl_load[t][s] = 1'b0;
      sl_done[t][s] = 1'b0;
    end

    if (reset_n) begin
      for (int t = 0; t < 2; t++) begin
        if (g[t] >= 0) begin
          sl_load[t][(cyc + 1) % SL]     = 1'b1;
          sl_data[t][(cyc + 1) % SL]     = req_data[g[t]*DW +: DW];
          sl_done[t][(cyc + 1 + L) % SL] = 1'b1;
          sl_id[t][(cyc + 1 + L) % SL]   = g[t];
          ptr_m[t] = (g[t] + 1) % N;
        end
      end
      pending = 1'b0;
      for (int t = 0; t < 2; t++)
        for (int j = 1; j <= L + 1; j++)
          if (sl_done[t][(cyc + j) % SL]) pending = 1'b1;
      case (mst)
        0: if (drain_req) mst = 1;
        1: begin
          if (!drain_req)    mst = 0;
          else if (!pending) mst = 2;
        end
        default: if (!drain_req) mst = 0;
      endcase
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    bit [N-1:0] a;
    for (int i = 0; i < n; i++) begin
      cycle(a);
      req_valid = req_valid & ~a;
    end
  endtask

  initial begin
    cyc       = 0;
    model_reset();
    reset_n   = 1'b1;
    drain_req = 1'b0;
    req_valid = '1;
    req_sel_b = '0;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
    #2 reset_n = 1'b0;
    @(negedge clk);

    // Reset held with every requester valid: nothing granted, outputs zero.
    cycle(acc);
    cycle(acc);
    cycle(acc);
    reset_n = 1'b1;
    // First cycle out of reset: req0 wins regA.
    cycle(acc);
    chk("first_grant_req0", 64'(acc), 64'h1);
    req_valid = '0;
    idle(4);

    // Single regA load from requester 1.
    req_valid = 4'b0010;
    req_sel_b = 4'b0000;
    req_data[1*DW +: DW] = 32'hDEADBEEF;
    cycle(acc);
    req_valid = req_valid & ~acc;
    idle(4);

    // All four held valid on regA: rotating grants, back-to-back dones.
    req_valid = 4'b1111;
    req_sel_b = 4'b0000;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 5; i++) cycle(acc);
    req_valid = '0;
    idle(4);

    // Dual target in one cycle.
    req_valid = 4'b0101;
    req_sel_b = 4'b0100;
    req_data[0*DW +: DW] = 32'h11;
    req_data[2*DW +: DW] = 32'h22;
    cycle(acc);
    chk("dual_grant", 64'(acc), 64'h5);
    req_valid = req_valid & ~acc;
    idle(4);

    // Drain with two loads in flight; a pending request must stay blocked.
    req_valid = 4'b0011;
    req_sel_b = 4'b0010;
    req_data[0*DW +: DW] = 32'h1234_5678;
    req_data[1*DW +: DW] = 32'h8765_4321;
    cycle(acc);
    req_valid = req_valid & ~acc;
    drain_req = 1'b1;
    req_valid = 4'b0100;
    req_sel_b = 4'b0000;
    req_data[2*DW +: DW] = 32'h0BAD_F00D;
    idle(7);
    drain_req = 1'b0;
    idle(5);

    // Reset one cycle after a grant: the load is lost without a done.
    req_valid = 4'b1111;
    req_sel_b = 4'b1010;
    cycle(acc);
    req_valid = '0;
    cycle(acc);
    reset_n = 1'b0;
    cycle(acc);
    reset_n = 1'b1;
    req_valid = 4'b1111;
    req_sel_b = 4'b0000;
    cycle(acc);
    chk("post_reset_ptr", 64'(acc), 64'h1);
    req_valid = '0;
    idle(4);

    // Randomized traffic with occasional drain toggles.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_sel_b[i] = 1'($urandom_range(0, 1));
          req_data[i*DW +: DW] = $urandom;
        end
      end
      if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
      cycle(acc);
      req_valid = req_valid & ~acc;
    end
    drain_req = 1'b0;
    req_valid = '0;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
